// File: rtl/lsu_pipelined.sv
// ---------------------------------------------------------------------------
// lsu_pipelined : pipelined load/store unit with in-order load-tag FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_pipelined #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int RD_W            = 4,
   parameter int ADDR_W          = 32,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_load,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [RD_W-1:0]   req_rd,
   input  logic [31:0]       req_wdata,
   output logic              m_req_valid,
   input  logic              m_req_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_we,
   output logic [31:0]       m_wdata,
   input  logic              m_rsp_valid,
   input  logic [31:0]       m_rsp_data,
   output logic              ld_valid,
   output logic [RD_W-1:0]   ld_rd,
   output logic [31:0]       ld_data,
   output logic              misalign,
   output logic [ADDR_W-1:0] misalign_addr,
   output logic [CNT_W-1:0]  outstanding,
   output logic              proto_err
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [RD_W-1:0]  tag_rd  [MAX_OUTSTANDING];
   logic [2:0]       tag_f3  [MAX_OUTSTANDING];
   logic [1:0]       tag_off [MAX_OUTSTANDING];

   logic        is_store;
   logic        is_load;
   logic        is_mem;
   logic [1:0]  off;
   logic        bad_align;
   logic        full;
   logic        push;
   logic        pop;
   logic        trap;
   logic [31:0] rsp_shifted;
   logic [31:0] rsp_ext;

   // A request with both load and store set is a store.
   assign is_store = req_is_store;
   assign is_load  = req_is_load & ~req_is_store;
   assign is_mem   = is_store | is_load;
   assign off      = req_addr[1:0];
   assign full     = (count == CNT_FULL);

   // Unsized/unsigned variants are illegal for stores; unused funct3 traps.
   always_comb begin
      bad_align = 1'b1;
      case (req_funct3)
         3'b000:  bad_align = 1'b0;
         3'b001:  bad_align = off[0];
         3'b010:  bad_align = (off != 2'b00);
         3'b100:  bad_align = is_store;
         3'b101:  bad_align = is_store | off[0];
         default: bad_align = 1'b1;
      endcase
   end

   always_comb begin
      m_req_valid = 1'b0;
      req_ready   = m_req_ready;
      if (req_valid && is_mem) begin
         if (bad_align) begin
            req_ready = 1'b1;
         end else if (is_store) begin
            m_req_valid = 1'b1;
         end else begin
            m_req_valid = ~full;
            req_ready   = m_req_ready & ~full;
         end
      end
   end

   assign m_addr = {req_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      m_we    = 4'b0000;
      m_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00:   m_wdata = {4{req_wdata[7:0]}};
         2'b01:   m_wdata = {2{req_wdata[15:0]}};
         default: m_wdata = req_wdata;
      endcase
      if (is_store && !bad_align) begin
         case (req_funct3[1:0])
            2'b00:   m_we = 4'b0001 << off;
            2'b01:   m_we = 4'b0011 << off;
            default: m_we = 4'b1111;
         endcase
      end
   end

   assign push = req_valid & is_load & ~bad_align & ~full & m_req_ready;
   assign pop  = m_rsp_valid & (count != '0);
   assign trap = req_valid & is_mem & bad_align;

   assign rsp_shifted = m_rsp_data >> {tag_off[rd_ptr], 3'b000};

   always_comb begin
      rsp_ext = rsp_shifted;
      case (tag_f3[rd_ptr])
         3'b000:  rsp_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
         3'b001:  rsp_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
         3'b100:  rsp_ext = {24'h0, rsp_shifted[7:0]};
         3'b101:  rsp_ext = {16'h0, rsp_shifted[15:0]};
         default: rsp_ext = rsp_shifted;
      endcase
   end

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Tag storage needs no reset: only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_rd[wr_ptr]  <= req_rd;
         tag_f3[wr_ptr]  <= req_funct3;
         tag_off[wr_ptr] <= off;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         ld_valid      <= 1'b0;
         ld_rd         <= '0;
         ld_data       <= '0;
         misalign      <= 1'b0;
         misalign_addr <= '0;
         proto_err     <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         ld_valid <= pop;
         if (pop) begin
            ld_rd   <= tag_rd[rd_ptr];
            ld_data <= rsp_ext;
         end
         misalign <= trap;
         if (trap) misalign_addr <= req_addr;
         if (m_rsp_valid && count == '0) proto_err <= 1'b1;
      end
   end

   assign outstanding = count;

endmodule

`default_nettype wire
